// File: rtl/march_pkg.sv
// March C element table, FSM state encoding and small helpers shared by the BIST engine.
package march_pkg;

  localparam int NUM_ELEM = 7;

  typedef struct packed {
    logic dir_down;
    logic has_read;
    logic read_val;
    logic has_write;
    logic write_val;
  } elem_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_CMP,
    ST_WR,
    ST_DONE
  } state_t;

  // The seven March C elements: up(w0) up(r0,w1) up(r1,w0) up(r0) down(r0,w1) down(r1,w0) up(r0)
  localparam elem_t MARCH_C [NUM_ELEM] = '{
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1},
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0},
    '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
    '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
    '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0}
  };

  function automatic elem_t elem_desc(input logic [2:0] idx);
    if (idx < 3'(NUM_ELEM)) return MARCH_C[idx];
    return '0;
  endfunction

  // Every address visit starts with its read when the element has one, else with its write.
  function automatic state_t first_op(input elem_t e);
    return e.has_read ? ST_RD : ST_WR;
  endfunction

endpackage

// File: rtl/march_addr_gen.sv
// Loadable up/down address counter; direction is latched at load so the end flags stay stable.
module march_addr_gen #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              first,
  output logic              last
);

  logic dir_down;

  // Load the element start address and direction, otherwise step in the latched direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      dir_down <= 1'b0;
    end else if (load) begin
      addr     <= load_down ? '1 : '0;
      dir_down <= load_down;
    end else if (step) begin
      addr <= dir_down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end
  end

  assign first = dir_down ? (addr == '1) : (addr == '0);
  assign last  = dir_down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/march_bist_ctrl.sv
// March C BIST engine: walks seven elements over the RAM, compares reads and records faults.
module march_bist_ctrl
  import march_pkg::*;
#(
  parameter int                ADDR_W       = 5,
  parameter int                DATA_W       = 8,
  parameter logic [DATA_W-1:0] BG0          = 8'h00,
  parameter logic [DATA_W-1:0] BG1          = 8'hFF,
  parameter int                RD_LAT       = 1,
  parameter int                CNT_W        = 8,
  parameter int                STOP_ON_FAIL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_en,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic [CNT_W-1:0]  fail_count
);

  localparam int WCNT_W    = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam int WAIT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  state_t            state, state_nxt;
  logic [2:0]        elem, elem_nxt, elem_inc;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  elem_t             cur;
  logic [DATA_W-1:0] exp_pat;
  logic              ld, ld_down, stp, adv, mismatch, accept, load_q;
  logic              addr_first, addr_last;

  march_addr_gen #(.ADDR_W(ADDR_W)) u_addr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ld),
    .load_down (ld_down),
    .step      (stp),
    .addr      (ram_addr),
    .first     (addr_first),
    .last      (addr_last)
  );

  assign cur      = elem_desc(elem);
  assign elem_inc = elem + 3'd1;
  assign exp_pat  = cur.read_val ? BG1 : BG0;
  assign mismatch = (state == ST_CMP) && (ram_data_out != exp_pat);
  assign accept   = (state == ST_IDLE) && start;

  assign busy         = (state == ST_RD) || (state == ST_WAIT) || (state == ST_CMP) || (state == ST_WR);
  assign ram_write_en = (state == ST_WR);
  assign ram_data_in  = (state == ST_WR) ? (cur.write_val ? BG1 : BG0) : '0;

  // Next state, element/address sequencing; advance happens in the last op of each address.
  always_comb begin
    state_nxt = state;
    elem_nxt  = elem;
    wcnt_nxt  = wcnt;
    ld        = 1'b0;
    ld_down   = elem_desc(elem_inc).dir_down;
    stp       = 1'b0;
    adv       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          ld        = 1'b1;
          ld_down   = elem_desc(3'd0).dir_down;
          elem_nxt  = 3'd0;
          state_nxt = first_op(elem_desc(3'd0));
        end
      end
      ST_RD: begin
        wcnt_nxt  = '0;
        state_nxt = (RD_LAT > 1) ? ST_WAIT : ST_CMP;
      end
      ST_WAIT: begin
        if (wcnt == WCNT_W'(WAIT_LAST)) state_nxt = ST_CMP;
        else wcnt_nxt = wcnt + WCNT_W'(1);
      end
      ST_CMP: begin
        if (mismatch && (STOP_ON_FAIL != 0)) state_nxt = ST_DONE;
        else if (cur.has_write) state_nxt = ST_WR;
        else adv = 1'b1;
      end
      ST_WR:   adv = 1'b1;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (adv) begin
      if (addr_last) begin
        if (elem == 3'(NUM_ELEM - 1)) begin
          state_nxt = ST_DONE;
        end else begin
          elem_nxt  = elem_inc;
          ld        = 1'b1;
          state_nxt = first_op(elem_desc(elem_inc));
        end
      end else begin
        stp       = 1'b1;
        state_nxt = first_op(cur);
      end
    end
  end

  // FSM state, element index and read-latency wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      elem   <= '0;
      wcnt   <= '0;
      load_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      elem   <= elem_nxt;
      wcnt   <= wcnt_nxt;
      load_q <= ld;
    end
  end

  // Run result: done flag, sticky fail, first-fault capture and saturating fail counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_data  <= '0;
      fail_count <= '0;
    end else if (accept) begin
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_data  <= '0;
      fail_count <= '0;
    end else begin
      if (state_nxt == ST_DONE) done <= 1'b1;
      if (mismatch) begin
        fail <= 1'b1;
        if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
        if (!fail) begin
          fail_addr <= ram_addr;
          fail_elem <= elem;
          fail_data <= ram_data_out;
        end
      end
    end
  end

  // A freshly loaded element must begin on its first address.
  always_ff @(posedge clk) begin
    if (rst_n && load_q) assert (addr_first);
  end

endmodule

// File: doc/march_bist_ctrl.md
Name: march_bist_ctrl

Overview:
- Hardware March C initiator that drives the team's single-port RAM (`clk`, `data_in`, `write_en`, `addr`, `data_out`).
- Replaces the bench-driven march sequence with a synthesizable engine. Runs seven march elements over every address, compares read data and reports faults.
- Sits beside the RAM and muxes onto its port while `busy` is high; the system owns the port otherwise.

Parameters:
- ADDR_W, 5, RAM address width; DEPTH = 2**ADDR_W locations.
- DATA_W, 8, RAM word width.
- BG0, 8'h00, background "0" pattern.
- BG1, 8'hFF, background "1" pattern.
- RD_LAT, 1, cycles from read address to valid `ram_data_out` (>=1).
- CNT_W, 8, fail counter width.
- STOP_ON_FAIL, 0, 1 = end the run at the first miscompare.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- busy  out  1  run in progress, RAM port owned.
- done  out  1  run finished; held until next accepted start.
- ram_addr  out  ADDR_W  RAM address.
- ram_data_in  out  DATA_W  RAM write data.
- ram_write_en  out  1  RAM write enable.
- ram_data_out  in  DATA_W  RAM read data.
- fail  out  1  sticky; any miscompare this run.
- fail_addr  out  ADDR_W  address of first miscompare.
- fail_elem  out  3  element index (0-6) of first miscompare.
- fail_data  out  DATA_W  read data at first miscompare.
- fail_count  out  CNT_W  miscompare count, saturating at all-ones.

Behaviour:
- Reset (async, any state): FSM returns to IDLE. All outputs are 0, including `ram_write_en` immediately.
- Elements, in order:
  - E0 up(w0)
  - E1 up(r0,w1)
  - E2 up(r1,w0)
  - E3 up(r0)
  - E4 down(r0,w1)
  - E5 down(r1,w0)
  - E6 up(r0)
- "0" means BG0 and "1" means BG1. "up" runs address 0..DEPTH-1; "down" runs DEPTH-1..0.
- FSM states:
  - IDLE: `start` accepted. Clears fail, fail_*, fail_count and done; sets busy on the next edge; enters E0 at address 0 or DEPTH-1 as the element requires.
  - RD: `ram_addr` = current address, `ram_write_en` = 0, for 1 cycle.
  - WAIT: RD_LAT-1 cycles; skipped when RD_LAT = 1.
  - CMP: samples `ram_data_out` and compares to the expected pattern.
    - Mismatch: fail = 1 and fail_count increments (saturating).
    - First mismatch of the run only: capture addr, elem and data.
  - WR: `ram_write_en` = 1, `ram_data_in` = pattern, address held, for 1 cycle.
  - DONE: busy = 0, done = 1; then back to IDLE, where done stays asserted.
- Per-address cycles:
  - w-only element: 1 (WR).
  - r-only element: 1+RD_LAT (RD, WAIT, CMP).
  - r+w element: 2+RD_LAT (RD, WAIT, CMP, WR).
- Element and address advance happen in the last cycle of each address's ops, with no bubble between addresses or elements.
- Busy length with defaults is exactly 32 + 96 + 96 + 64 + 96 + 96 + 64 = 544 cycles.
- STOP_ON_FAIL = 1: a miscompare in CMP goes straight to DONE, skipping that address's write.
- `start` while busy is ignored. `start` in the DONE state is ignored; it is accepted from IDLE only.
- Outside RD/WR: `ram_write_en` = 0, `ram_addr` holds its last value, `ram_data_in` = 0.
- Address counter wraps only at element boundaries, never mid-element.

Decomposition:
- Package `march_pkg`:
  - Element descriptor struct: dir_down, has_read, read_val, has_write, write_val.
  - Constant 7-entry March C table.
  - FSM state enum.
  - NUM_ELEM = 7.
- Sub-module `march_addr_gen`: loadable up/down ADDR_W counter with `first`/`last` flags. `last` is asserted at DEPTH-1 for up elements and at 0 for down elements.

Test Plan:
- Fault-free behavioural RAM, defaults, pulse start -> busy high exactly 544 cycles, then done = 1, fail = 0, fail_count = 0.
- Port sequence check -> E0 writes 8'h00 to addrs 0..31 ascending, 1 cycle each. The first E4 read address is 31; the final E6 read address is 31.
- Stuck-at-0 on bit 0 at addr 5 -> fail = 1, fail_addr = 5, fail_elem = 2, fail_data = 8'hFE, fail_count = 2 (E2, E5), full 544-cycle run.
- Stuck-at-1 on bit 7 at addr 31 -> fail_elem = 1, fail_addr = 31, fail_data = 8'h80, fail_count = 4 (E1, E3, E4, E6).
- STOP_ON_FAIL = 1 with the addr-5 stuck-at-0 fault -> done follows the E2 addr-5 CMP cycle, with no write to addr 5 in E2; fail_count = 1.
- Two mid-run cases:
  - Start pulse at busy cycle 50 -> ignored.
  - rst_n low at busy cycle 100 -> all outputs 0 asynchronously. A subsequent start completes 544 cycles with fail = 0.
